mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the IF-stage instruction fetch port (I) and the MEM-stage load/store port (D).
- Holds at most one outstanding transaction.
- Fixed D priority with a starvation guard for I.
- Supports an IF-flush kill that discards an in-flight fetch response.
- Sits between the pipeline stages and a shared instruction/data RAM; its grant and valid signals drive the stage stall logic.

Parameters:
AW, 32, address width of all ports.
MAX_D_STREAK, 4, max consecutive D grants while i_req is pending before I is forced to win (>=1).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request
i_addr  in  AW  fetch address
i_kill  in  1  flush: discard pending/in-flight fetch
i_gnt  out  1  fetch request accepted (1-cycle pulse)
i_rvalid  out  1  fetch data valid (1-cycle pulse)
i_rdata  out  32  fetch data
d_req  in  1  load/store request
d_we  in  1  1=store
d_addr  in  AW  data address
d_wdata  in  32  store data
d_strb  in  4  byte enables
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data / store ack valid (1-cycle pulse)
d_rdata  out  32  load data
m_req  out  1  memory request
m_we  out  1  memory write
m_addr  out  AW  memory address
m_wdata  out  32  memory write data
m_strb  out  4  memory byte enables
m_gnt  in  1  memory accepted request
m_rvalid  in  1  memory response/ack (one per accepted request)
m_rdata  in  32  memory read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE; streak=0; drop=0; all m_* and i_/d_ gnt/rvalid outputs 0; rdata outputs 0.
- FSM states: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- IDLE arbitration, same cycle as sampling requests:
  - I is eligible iff i_req & !i_kill.
  - Winner is D if d_req and (!eligible I or streak < MAX_D_STREAK); otherwise I if eligible.
  - Winner's gnt pulses this cycle. The arbiter registers addr/we/wdata/strb (I side: we=0, strb=4'hF) and moves to REQ_x.
  - Requesters may change or drop req the cycle after gnt.
- Streak counter:
  - D grant while i_req=1: streak++, saturating at MAX_D_STREAK.
  - Any I grant, or IDLE with i_req=0: streak=0.
- REQ_x:
  - m_req=1 and m_* held stable from the registered values until m_gnt. Retraction is not allowed.
  - On m_gnt, go to WAIT_x.
  - m_rvalid in the same cycle as m_gnt is legal: the response is returned that cycle and the FSM goes to IDLE directly.
- WAIT_x:
  - m_req=0. On m_rvalid, return the response and go to IDLE.
  - Next arbitration happens the cycle after returning to IDLE, so there is no back-to-back issue. Minimum cycle: gnt (IDLE) -> m_req -> m_gnt+rvalid = 2 cycles.
- Response path is combinational:
  - i_rvalid = m_rvalid & (state in REQ_I/WAIT_I) & !drop & !i_kill.
  - d_rvalid = m_rvalid & (state in REQ_D/WAIT_D).
  - i_rdata/d_rdata = m_rdata when the respective rvalid=1, otherwise 0.
- Kill:
  - i_kill in REQ_I or WAIT_I sets drop=1. The bus transaction still completes; its i_rvalid is suppressed.
  - drop clears on return to IDLE.
  - i_kill has no effect on D transactions.
- Error case: m_rvalid or m_gnt in IDLE is ignored.
- Reset mid-transaction: immediate return to IDLE. The memory shares rst and discards its in-flight operation.

Test Plan:
- Single fetch: i_req=1, addr=0x100 in IDLE; m_gnt 1 cycle after m_req; m_rvalid 2 cycles later with 0xDEADBEEF -> i_gnt at T0, m_req T1, i_rvalid=1 with i_rdata=0xDEADBEEF at T4, busy 0 at T5.
- Simultaneous requests: i_req=d_req=1, d_we=1, d_addr=0x200, d_wdata=0x55AA, strb=4'b0011 -> d_gnt first, m_we=1, m_strb=0011; i_gnt in the first IDLE after d_rvalid.
- Starvation guard (MAX_D_STREAK=4): continuous d_req and i_req -> exactly 4 d_gnt pulses, then i_gnt, then streak reset and D wins again.
- Kill in flight: fetch to 0x300 granted; i_kill pulsed during WAIT_I -> m_rvalid arrives, i_rvalid stays 0, FSM returns to IDLE, next fetch at 0x304 returns data normally.
- Zero-wait memory: m_gnt and m_rvalid both asserted in the first REQ_D cycle for a load of 0x1234 -> d_rvalid=1 with d_rdata=0x1234 that cycle, IDLE next cycle.
- Reset mid-transaction: rst=1 during WAIT_D -> next cycle busy=0, m_req=0, no d_rvalid. A late m_rvalid after reset is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the shared memory and
// the arbiter. The slave modport is the arbiter's view; the master modport is
// the view of the environment: the pipeline stages plus the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    // Fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_kill;
    logic          i_gnt;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_strb;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    // Memory port
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_strb;
    logic          m_gnt;
    logic          m_rvalid;
    logic [31:0]   m_rdata;
    // Status and FSM debug view
    logic          busy;
    logic [2:0]    fsm_state;

    modport slave (
        input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_strb,
               m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_strb, busy, fsm_state
    );

    modport master (
        output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, d_strb,
               m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_req, m_we, m_addr, m_wdata, m_strb, busy, fsm_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D)
// ports. One transaction outstanding at a time, D has fixed priority, and a
// streak counter forces an I grant after MAX_D_STREAK back-to-back D grants
// while a fetch is waiting.
//
// Handshake: a requester holds *_req until it sees the same-cycle *_gnt
// pulse in IDLE; the arbiter then owns the request. Towards memory, m_req and
// all m_* payload stay stable until m_gnt; exactly one m_rvalid follows each
// accepted request, possibly in the same cycle as m_gnt. *_rvalid pulses for
// one cycle and is passed through combinationally from m_rvalid.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ_I  = 3'd1;
    localparam logic [2:0] REQ_D  = 3'd2;
    localparam logic [2:0] WAIT_I = 3'd3;
    localparam logic [2:0] WAIT_D = 3'd4;

    localparam int            SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [SW-1:0] streak;
    logic          drop;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;

    logic i_elig;
    logic d_win;
    logic i_win;
    logic on_i;
    logic on_d;
    logic on_req;
    logic resp;

    // Arbitration and response qualification; nothing is granted or
    // returned during the reset cycle.
    always_comb begin
        i_elig = bus.i_req & ~bus.i_kill;
        d_win  = (state == IDLE) & ~rst & bus.d_req &
                 (~i_elig | (streak < STREAK_MAX));
        i_win  = (state == IDLE) & ~rst & i_elig & ~d_win;
        on_i   = (state == REQ_I) | (state == WAIT_I);
        on_d   = (state == REQ_D) | (state == WAIT_D);
        on_req = (state == REQ_I) | (state == REQ_D);
        resp   = bus.m_rvalid & ~rst;
    end

    // Next-state logic; a same-cycle m_gnt + m_rvalid skips the WAIT state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_win)      state_nxt = REQ_D;
                else if (i_win) state_nxt = REQ_I;
            end
            REQ_I:  if (bus.m_gnt) state_nxt = bus.m_rvalid ? IDLE : WAIT_I;
            REQ_D:  if (bus.m_gnt) state_nxt = bus.m_rvalid ? IDLE : WAIT_D;
            WAIT_I: if (bus.m_rvalid) state_nxt = IDLE;
            WAIT_D: if (bus.m_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, captured request payload, starvation streak and kill flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            streak  <= '0;
            drop    <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state <= state_nxt;

            if (d_win) begin
                addr_q  <= bus.d_addr;
                we_q    <= bus.d_we;
                wdata_q <= bus.d_wdata;
                strb_q  <= bus.d_strb;
            end else if (i_win) begin
                addr_q  <= bus.i_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                strb_q  <= 4'hF;
            end

            // The streak only counts D wins that actually made a fetch wait.
            if (state == IDLE) begin
                if (i_win || !bus.i_req)
                    streak <= '0;
                else if (d_win && (streak < STREAK_MAX))
                    streak <= streak + 1'b1;
            end

            // A killed fetch still finishes on the bus; only its data is dropped.
            if (state_nxt == IDLE)
                drop <= 1'b0;
            else if (on_i && bus.i_kill)
                drop <= 1'b1;
        end
    end

    // Grants, memory request and combinational response routing.
    always_comb begin
        bus.i_gnt     = i_win;
        bus.d_gnt     = d_win;
        bus.m_req     = on_req;
        bus.m_we      = on_req & we_q;
        bus.m_addr    = on_req ? addr_q  : '0;
        bus.m_wdata   = on_req ? wdata_q : '0;
        bus.m_strb    = on_req ? strb_q  : '0;
        bus.i_rvalid  = resp & on_i & ~drop & ~bus.i_kill;
        bus.d_rvalid  = resp & on_d;
        bus.i_rdata   = bus.i_rvalid ? bus.m_rdata : '0;
        bus.d_rdata   = bus.d_rvalid ? bus.m_rdata : '0;
        bus.busy      = (state != IDLE);
        bus.fsm_state = state;
    end
endmodule
